// File: rtl/i2c_reg_sequencer_if.sv
// Bundles the register-request/response handshake and the byte-level control link
// between the sequencer and the i2c master. clk_in/reset stay plain ports on the module.
interface i2c_reg_sequencer_if;
  // Request channel
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  // Response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  // Control towards the i2c master
  logic       transfer_start;
  logic       transfer_continue;
  logic       mode;
  logic [7:0] data_tx;
  // Status from the i2c master
  logic       transfer_ready;
  logic       interrupt;
  logic       transaction_complete;
  logic       nack;
  logic [7:0] data_rx;
  logic       start_err;
  logic       arbitration_err;

  // Sequencer side: serves requests and drives the master's control inputs.
  modport slave (
    input  req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
    input  transfer_ready, interrupt, transaction_complete, nack, data_rx,
    input  start_err, arbitration_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output transfer_start, transfer_continue, mode, data_tx
  );

  // Environment side: the requester plus the i2c master itself.
  modport master (
    output req_valid, req_write, req_dev_addr, req_reg_addr, req_wdata, rsp_ready,
    output transfer_ready, interrupt, transaction_complete, nack, data_rx,
    output start_err, arbitration_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  transfer_start, transfer_continue, mode, data_tx
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register read/write request into the i2c master's
// byte handshake (START dev+W, reg, [wdata | Sr dev+R, rdata], STOP), watches for
// NACK, bus errors and stalls, and returns exactly one response per accepted request.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic               clk_in,
  input logic               reset,
  i2c_reg_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_SYNC,       // wait for an idle bus before serving requests
    S_IDLE,       // ready for a request
    S_ADDR_W,     // device address + W in flight
    S_REG,        // register address in flight
    S_WDATA,      // write data in flight
    S_ADDR_R,     // repeated START + device address + R in flight
    S_RDATA,      // read data in flight (master NACKs it)
    S_ABORT,      // slave NACKed: make the master issue STOP
    S_STOP_WAIT,  // wait for STOP and bus-free time
    S_TMO_WAIT,   // timed out: wait for the bus to release before responding
    S_RESP        // response presented until consumed
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_BUS     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic        write_q, write_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ts_q, ts_d;
  logic        tc_q, tc_d;
  logic        mode_q, mode_d;
  logic [7:0]  data_tx_q, data_tx_d;

  logic active;
  logic bus_err;
  logic tmo_hit;

  assign active  = (state_q == S_ADDR_W) || (state_q == S_REG)   || (state_q == S_WDATA) ||
                   (state_q == S_ADDR_R) || (state_q == S_RDATA) || (state_q == S_ABORT) ||
                   (state_q == S_STOP_WAIT);
  assign bus_err = bus.start_err || bus.arbitration_err;
  // A bus that just became free in STOP_WAIT wins over a coincident expiry.
  assign tmo_hit = TMO_EN && active && (cnt_q == TMO_LAST) && !bus.interrupt &&
                   !((state_q == S_STOP_WAIT) && bus.transfer_ready);

  // Next-state, request latch, timeout counter and master-control updates.
  always_comb begin
    // NOTE: every *_d starts from its *_q, so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    err_d     = err_q;
    write_d   = write_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    ts_d      = ts_q;
    tc_d      = tc_q;
    mode_d    = mode_q;
    data_tx_d = data_tx_q;

    // Inter-interrupt watchdog: saturates instead of wrapping.
    if (active) begin
      if (bus.interrupt) begin
        cnt_d = '0;
      end else if (cnt_q != TMO_LAST) begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    unique case (state_q)
      S_SYNC: begin
        if (bus.transfer_ready) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d   = bus.req_write;
          dev_d     = bus.req_dev_addr;
          reg_d     = bus.req_reg_addr;
          wdata_d   = bus.req_wdata;
          rdata_d   = 8'h00;
          err_d     = ERR_OK;
          cnt_d     = '0;
          ts_d      = 1'b1;
          tc_d      = 1'b1;
          mode_d    = 1'b0;
          data_tx_d = {bus.req_dev_addr, 1'b0};
          state_d   = S_ADDR_W;
        end
      end
      S_ADDR_W: begin
        if (bus.transaction_complete) begin
          if (bus.nack) begin
            // Drop control now so the master sees a stop request on its next sample.
            ts_d    = 1'b0;
            tc_d    = 1'b0;
            err_d   = ERR_NACK;
            state_d = S_ABORT;
          end else begin
            ts_d      = 1'b0;
            tc_d      = 1'b1;
            data_tx_d = reg_q;
            state_d   = S_REG;
          end
        end
      end
      S_REG: begin
        if (bus.transaction_complete) begin
          if (bus.nack) begin
            ts_d    = 1'b0;
            tc_d    = 1'b0;
            err_d   = ERR_NACK;
            state_d = S_ABORT;
          end else if (write_q) begin
            data_tx_d = wdata_q;
            tc_d      = 1'b0;
            state_d   = S_WDATA;
          end else begin
            ts_d      = 1'b1;
            tc_d      = 1'b1;
            mode_d    = 1'b0;
            data_tx_d = {dev_q, 1'b1};
            state_d   = S_ADDR_R;
          end
        end
      end
      S_WDATA: begin
        if (bus.transaction_complete) begin
          ts_d    = 1'b0;
          err_d   = bus.nack ? ERR_NACK : ERR_OK;
          state_d = S_STOP_WAIT;
        end
      end
      S_ADDR_R: begin
        if (bus.transaction_complete) begin
          if (bus.nack) begin
            ts_d    = 1'b0;
            tc_d    = 1'b0;
            err_d   = ERR_NACK;
            state_d = S_ABORT;
          end else begin
            ts_d    = 1'b0;
            mode_d  = 1'b1;
            tc_d    = 1'b0;
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        if (bus.transaction_complete) begin
          rdata_d = bus.data_rx;
          ts_d    = 1'b0;
          err_d   = ERR_OK;
          state_d = S_STOP_WAIT;
        end
      end
      S_ABORT: begin
        ts_d    = 1'b0;
        tc_d    = 1'b0;
        state_d = S_STOP_WAIT;
      end
      S_STOP_WAIT: begin
        if (bus.transfer_ready) state_d = S_RESP;
      end
      S_TMO_WAIT: begin
        if (bus.transfer_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase

    // The master has already released the bus on these errors, so there is no STOP to wait for.
    if (active && bus_err) begin
      ts_d    = 1'b0;
      tc_d    = 1'b0;
      err_d   = ERR_BUS;
      state_d = S_RESP;
    end else if (tmo_hit) begin
      ts_d      = 1'b0;
      tc_d      = 1'b0;
      mode_d    = 1'b0;
      data_tx_d = 8'h00;
      err_d     = ERR_TIMEOUT;
      state_d   = S_TMO_WAIT;
    end
  end

  // State and datapath registers; reset clears everything the block drives.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset) begin
      state_q   <= S_SYNC;
      err_q     <= ERR_OK;
      write_q   <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      cnt_q     <= '0;
      ts_q      <= 1'b0;
      tc_q      <= 1'b0;
      mode_q    <= 1'b0;
      data_tx_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      write_q   <= write_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      ts_q      <= ts_d;
      tc_q      <= tc_d;
      mode_q    <= mode_d;
      data_tx_q <= data_tx_d;
    end
  end

  assign bus.req_ready         = (state_q == S_IDLE);
  assign bus.rsp_valid         = (state_q == S_RESP);
  assign bus.rsp_err           = err_q;
  assign bus.rsp_rdata         = (err_q == ERR_OK) ? rdata_q : 8'h00;
  assign bus.transfer_start    = ts_q;
  assign bus.transfer_continue = tc_q;
  assign bus.mode              = mode_q;
  assign bus.data_tx           = data_tx_q;

endmodule
